// File: rtl/conv2d_stream_engine.sv
// Streaming KxK 2-D convolution over raster-order signed pixels.
// Line buffers feed a KxK window; a shadow/active weight bank keeps one kernel per frame.
module conv2d_stream_engine #(
   parameter int IMG_W    = 32,
   parameter int IMG_H    = 32,
   parameter int K        = 5,
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 0,
   parameter int RELU     = 0
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic                       iValid,
   input  logic signed [DATA_W-1:0]   iX,
   input  logic                       iWren,
   input  logic [$clog2(K*K)-1:0]     iADDR,
   input  logic signed [WEIGHT_W-1:0] iW,
   output logic signed [OUT_W-1:0]    oY,
   output logic                       oValid,
   output logic                       oSat,
   output logic                       oFrameDone
);
   localparam int NTAP  = K * K;
   localparam int AW    = $clog2(NTAP);
   localparam int PW    = DATA_W + WEIGHT_W;
   localparam int ACC_W = PW + $clog2(NTAP);
   localparam int EW    = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);

   localparam logic signed [EW-1:0] RND   = EW'((2 ** SHIFT) / 2);
   localparam logic signed [EW-1:0] MAX_V = EW'((longint'(1) <<< (OUT_W - 1)) - 1);
   localparam logic signed [EW-1:0] MIN_V = -MAX_V - EW'(1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          first_pix;
   logic          win_ok;
   logic          last_pix;

   logic signed [DATA_W-1:0]   line_buf [K-1][IMG_W];
   logic signed [DATA_W-1:0]   col_vec  [K];
   logic signed [DATA_W-1:0]   win      [K][K];
   logic signed [WEIGHT_W-1:0] shadow   [NTAP];
   logic signed [WEIGHT_W-1:0] active   [NTAP];
   logic signed [PW-1:0]       prod     [NTAP];
   logic signed [ACC_W-1:0]    tree_sum;
   logic signed [ACC_W-1:0]    acc;
   logic signed [EW-1:0]       ext;
   logic signed [EW-1:0]       shifted;
   logic signed [OUT_W-1:0]    clip;
   logic signed [OUT_W-1:0]    y_next;
   logic                       sat_hi;
   logic                       sat_lo;

   logic v0, v1, v2;
   logic l0, l1, l2;

   assign first_pix = iValid && (col == '0) && (row == '0);
   assign win_ok    = iValid && (col >= CW'(K - 1)) && (row >= RW'(K - 1));
   assign last_pix  = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         col <= '0;
         row <= '0;
      end else if (iValid) begin
         if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Column entering the window: K-1 older rows from the line buffers, newest pixel at the bottom.
   always_comb begin
      for (int i = 0; i < K - 1; i++) col_vec[i] = line_buf[i][col];
      col_vec[K-1] = iX;
   end

   always_ff @(posedge iCLK) begin
      if (iValid) begin
         for (int i = 0; i < K - 1; i++) line_buf[i][col] <= col_vec[i+1];
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
            win[i][K-1] <= col_vec[i];
         end
      end
   end

   // Active bank takes the pre-edge shadow, so a write on the copy edge lands next frame.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int t = 0; t < NTAP; t++) begin
            shadow[t] <= '0;
            active[t] <= '0;
         end
      end else begin
         if (iWren && (iADDR < AW'(NTAP))) shadow[iADDR] <= iW;
         if (first_pix) begin
            for (int t = 0; t < NTAP; t++) active[t] <= shadow[t];
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         v2 <= 1'b0;
         l0 <= 1'b0;
         l1 <= 1'b0;
         l2 <= 1'b0;
      end else begin
         v0 <= win_ok;
         v1 <= v0;
         v2 <= v1;
         l0 <= win_ok && last_pix;
         l1 <= l0;
         l2 <= l1;
      end
   end

   always_ff @(posedge iCLK) begin
      for (int t = 0; t < NTAP; t++) prod[t] <= PW'(win[t / K][t % K]) * PW'(active[t]);
      acc <= tree_sum;
   end

   always_comb begin
      tree_sum = '0;
      for (int t = 0; t < NTAP; t++) tree_sum = tree_sum + ACC_W'(prod[t]);
   end

   always_comb begin
      ext     = EW'(acc);
      shifted = (ext + RND) >>> SHIFT;
      sat_hi  = shifted > MAX_V;
      sat_lo  = shifted < MIN_V;
      if (sat_hi)      clip = MAX_V[OUT_W-1:0];
      else if (sat_lo) clip = MIN_V[OUT_W-1:0];
      else             clip = shifted[OUT_W-1:0];
      if ((RELU != 0) && clip[OUT_W-1]) y_next = '0;
      else                              y_next = clip;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oY         <= '0;
         oSat       <= 1'b0;
         oValid     <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oValid     <= v2;
         oFrameDone <= l2;
         if (v2) begin
            oY   <= y_next;
            oSat <= sat_hi | sat_lo;
         end
      end
   end
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Bench for conv2d_stream_engine: two instances (plain, and RELU with rounding shift)
// checked every cycle against a frame-level convolution model.
module tb_conv2d_stream_engine;
   localparam int IMG_W   = 32;
   localparam int IMG_H   = 32;
   localparam int K       = 5;
   localparam int NTAP    = K * K;
   localparam int NRES    = (IMG_W - K + 1) * (IMG_H - K + 1);
   localparam int SHIFT_B = 2;

   logic              iCLK = 1'b0;
   logic              iRST = 1'b0;
   logic              iValid = 1'b0;
   logic signed [7:0] iX = '0;
   logic              iWren = 1'b0;
   logic [4:0]        iADDR = '0;
   logic signed [7:0] iW = '0;
   logic signed [15:0] y_a, y_b;
   logic              val_a, val_b, sat_a, sat_b, fd_a, fd_b;

   conv2d_stream_engine dut_a (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iX(iX), .iWren(iWren), .iADDR(iADDR), .iW(iW),
      .oY(y_a), .oValid(val_a), .oSat(sat_a), .oFrameDone(fd_a));

   conv2d_stream_engine #(.SHIFT(SHIFT_B), .RELU(1)) dut_b (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iX(iX), .iWren(iWren), .iADDR(iADDR), .iW(iW),
      .oY(y_b), .oValid(val_b), .oSat(sat_b), .oFrameDone(fd_b));

   always #5 iCLK = ~iCLK;

   typedef struct {
      int ya;
      bit sa;
      int yb;
      bit sb;
      bit fd;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   shadow_m [NTAP];
   int   act_k [NTAP];
   int   img [IMG_H][IMG_W];
   int   cyc = 0;
   int   acc_cyc = 0;
   int   first_cyc = 0;
   int   n_valid = 0;
   int   fd_count = 0;
   int   fd_idx = 0;
   int   lit_mode = 0;
   int   lit_ya, lit_yb;
   bit   lit_sa, lit_sb;
   int   last_ya = 0, last_yb = 0;
   bit   last_sa = 0, last_sb = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic void post(input longint s, input int sh, input bit relu,
                                output int y, output bit sat);
      longint t;
      t = s;
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      sat = 1'b0;
      if (t > 32767) begin
         t = 32767;
         sat = 1'b1;
      end else if (t < -32768) begin
         t = -32768;
         sat = 1'b1;
      end
      if (relu && t < 0) t = 0;
      y = int'(t);
   endfunction

   // Per-cycle compare of both instances against the model queue.
   always @(negedge iCLK) begin
      exp_t e;
      int idx, rr, cc, v;
      if (!iRST) begin
         if (val_a || val_b) begin
            check("valid_pair", val_b, val_a);
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid: oValid=1 at cycle %0d, required no result pending", cyc);
            end else begin
               e = q.pop_front();
               check("y_a", y_a, e.ya);
               check("sat_a", sat_a, e.sa);
               check("y_b", y_b, e.yb);
               check("sat_b", sat_b, e.sb);
               check("fd_a", fd_a, e.fd);
               check("fd_b", fd_b, e.fd);
               if (lit_mode == 1) begin
                  check("lit_y_a", y_a, lit_ya);
                  check("lit_y_b", y_b, lit_yb);
                  check("lit_sat_a", sat_a, lit_sa);
                  check("lit_sat_b", sat_b, lit_sb);
               end else if (lit_mode == 2) begin
                  idx = n_valid % NRES;
                  rr = idx / (IMG_W - K + 1);
                  cc = idx % (IMG_W - K + 1);
                  v = ((rr + 2) * IMG_W + cc + 2) % 128;
                  check("ramp_y_a", y_a, v);
                  check("ramp_y_b", y_b, (v + 2) >>> 2);
               end
               last_ya = e.ya; last_sa = e.sa; last_yb = e.yb; last_sb = e.sb;
            end
            if (n_valid == 0) first_cyc = cyc;
            n_valid++;
            if (fd_a) begin
               fd_count++;
               fd_idx = n_valid;
            end
         end else begin
            check("hold_y_a", y_a, last_ya);
            check("hold_sat_a", sat_a, last_sa);
            check("hold_y_b", y_b, last_yb);
            check("hold_sat_b", sat_b, last_sb);
            check("idle_fd", fd_a | fd_b, 0);
         end
      end
   end

   task automatic do_reset();
      iRST = 1'b1;
      iValid = 1'b0;
      iWren = 1'b0;
      q.delete();
      last_ya = 0; last_yb = 0; last_sa = 0; last_sb = 0;
      for (int t = 0; t < NTAP; t++) shadow_m[t] = 0;
      #2;
      check("rst_y", y_a | y_b, 0);
      check("rst_valid", val_a | val_b, 0);
      check("rst_sat", sat_a | sat_b, 0);
      check("rst_fd", fd_a | fd_b, 0);
      @(posedge iCLK);
      @(posedge iCLK);
      #1;
      iRST = 1'b0;
   endtask

   task automatic write_w(input int a, input int v);
      iWren = 1'b1;
      iADDR = 5'(a);
      iW = 8'(v);
      if (a < NTAP) shadow_m[a] = v;
      @(posedge iCLK);
      #1;
      iWren = 1'b0;
   endtask

   task automatic load_kernel(input int v);
      for (int a = 0; a < NTAP; a++) write_w(a, v);
   endtask

   task automatic send_frame(input int pat, input int v, input int gap_pct, input int wr_mode,
                             input int npix, output int first_y);
      longint s;
      int ya, yb;
      bit sa, sb;
      exp_t e;
      for (int rr = 0; rr < IMG_H; rr++)
         for (int cc = 0; cc < IMG_W; cc++)
            img[rr][cc] = (pat == 0) ? v : (rr * IMG_W + cc) % 128;
      for (int t = 0; t < NTAP; t++) act_k[t] = shadow_m[t];
      first_y = 0;
      for (int rr = 0; rr <= IMG_H - K; rr++) begin
         for (int cc = 0; cc <= IMG_W - K; cc++) begin
            s = 0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  s += longint'(act_k[i*K+j]) * img[rr+i][cc+j];
            post(s, 0, 1'b0, ya, sa);
            post(s, SHIFT_B, 1'b1, yb, sb);
            e.ya = ya; e.sa = sa; e.yb = yb; e.sb = sb;
            e.fd = (rr == IMG_H - K) && (cc == IMG_W - K);
            if (rr == 0 && cc == 0) first_y = ya;
            q.push_back(e);
         end
      end
      for (int p = 0; p < npix; p++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            iValid = 1'b0;
            iWren = 1'b0;
            @(posedge iCLK);
            #1;
         end
         iValid = 1'b1;
         iX = 8'(img[p / IMG_W][p % IMG_W]);
         iWren = 1'b0;
         if (wr_mode == 1 && p >= 300 && p < 300 + NTAP) begin
            iWren = 1'b1; iADDR = 5'(p - 300); iW = 8'sd2; shadow_m[p-300] = 2;
         end else if (wr_mode == 2 && p == 0) begin
            iWren = 1'b1; iADDR = 5'd0; iW = 8'sd3; shadow_m[0] = 3;
         end
         @(posedge iCLK);
         #1;
         if (p == 4 * IMG_W + 4) acc_cyc = cyc;
      end
      iValid = 1'b0;
      iWren = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge iCLK);
         #1;
         n++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d results still pending, required 0", name, q.size());
      end
      repeat (4) @(posedge iCLK);
      #1;
   endtask

   task automatic start_test(input int mode, input int ya, input int yb, input bit sa, input bit sb);
      lit_mode = mode;
      lit_ya = ya; lit_yb = yb; lit_sa = sa; lit_sb = sb;
      n_valid = 0;
      fd_count = 0;
      fd_idx = 0;
   endtask

   initial begin
      int fy;
      #1;
      do_reset();

      // T1: out-of-range taps must be ignored, then an all-1 kernel over an all-1 frame
      for (int a = NTAP; a < 32; a++) write_w(a, 7);
      load_kernel(1);
      start_test(1, 25, 6, 1'b0, 1'b0);
      send_frame(0, 1, 0, 0, 1024, fy);
      check("T1_model_y", fy, 25);
      drain("T1");
      check("T1_count", n_valid, NRES);
      check("T1_fd_count", fd_count, 1);
      check("T1_fd_idx", fd_idx, NRES);

      // T2: centre tap only over a ramp, plus first-result latency
      load_kernel(0);
      write_w(12, 1);
      start_test(2, 0, 0, 1'b0, 1'b0);
      send_frame(1, 0, 0, 0, 1024, fy);
      check("T2_model_y", fy, 66);
      drain("T2");
      check("T2_count", n_valid, NRES);
      check("T2_latency", first_cyc - acc_cyc, 3);

      // T3: saturation in both directions, ReLU on the negative clip
      load_kernel(127);
      start_test(1, 32767, 32767, 1'b1, 1'b1);
      send_frame(0, 127, 0, 0, 1024, fy);
      drain("T3a");
      check("T3a_count", n_valid, NRES);
      load_kernel(-128);
      start_test(1, -32768, 0, 1'b1, 1'b1);
      send_frame(0, 127, 0, 0, 1024, fy);
      check("T3b_model_y", fy, -32768);
      drain("T3b");
      check("T3b_count", n_valid, NRES);

      // T4: T2 stimulus with input bubbles
      load_kernel(0);
      write_w(12, 1);
      start_test(2, 0, 0, 1'b0, 1'b0);
      send_frame(1, 0, 30, 0, 1024, fy);
      drain("T4");
      check("T4_count", n_valid, NRES);

      // T5: kernel rewritten mid-frame, and a write on the copy edge, back-to-back frames
      load_kernel(1);
      start_test(0, 0, 0, 1'b0, 1'b0);
      send_frame(0, 1, 0, 1, 1024, fy);
      check("T5_f1_model_y", fy, 25);
      send_frame(0, 1, 0, 2, 1024, fy);
      check("T5_f2_model_y", fy, 50);
      send_frame(0, 1, 0, 0, 1024, fy);
      check("T5_f3_model_y", fy, 51);
      drain("T5");
      check("T5_count", n_valid, 3 * NRES);
      check("T5_fd_count", fd_count, 3);

      // T6: reset mid-frame, reload, resend
      load_kernel(1);
      start_test(1, 25, 6, 1'b0, 1'b0);
      send_frame(0, 1, 0, 0, 500, fy);
      do_reset();
      load_kernel(1);
      start_test(1, 25, 6, 1'b0, 1'b0);
      repeat (6) @(posedge iCLK);
      #1;
      check("T6_no_stale", n_valid, 0);
      send_frame(0, 1, 0, 0, 1024, fy);
      drain("T6");
      check("T6_count", n_valid, NRES);
      check("T6_fd_count", fd_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
